// File: rtl/csr_fu_fwd_if.sv
// Request/response bundle between the EXE-stage issue logic and the registered CSR unit.
// The master side issues CSR instructions and consumes results; the slave side is the CSR unit.
interface csr_fu_fwd_if #(
  parameter int XLEN    = 32,
  parameter int GPR_ASZ = 5,
  parameter int DEPTH   = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [11:0]              csr_addr;
  logic [2:0]               funct3;
  logic [GPR_ASZ-1:0]       Rd_addr;
  logic [GPR_ASZ-1:0]       Rs1_addr;
  logic [XLEN-1:0]          Rs1_data;
  logic [1:0]               mode;
  logic                     csr_avail;
  logic [XLEN-1:0]          csr_rd_data;
  logic                     sw_irq;
  logic                     flush;
  logic                     retire;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_Rd_data;
  logic                     out_csr_rd;
  logic                     out_csr_wr;
  logic [11:0]              out_csr_addr;
  logic [XLEN-1:0]          out_csr_wr_data;
  logic                     out_ill;
  logic [11:0]              out_ill_addr;
  logic [$clog2(DEPTH):0]   pend_cnt;

  modport master (
    output req_valid, csr_addr, funct3, Rd_addr, Rs1_addr, Rs1_data, mode,
           csr_avail, csr_rd_data, sw_irq, flush, retire, out_ready,
    input  req_ready, out_valid, out_Rd_data, out_csr_rd, out_csr_wr,
           out_csr_addr, out_csr_wr_data, out_ill, out_ill_addr, pend_cnt
  );

  modport slave (
    input  req_valid, csr_addr, funct3, Rd_addr, Rs1_addr, Rs1_data, mode,
           csr_avail, csr_rd_data, sw_irq, flush, retire, out_ready,
    output req_ready, out_valid, out_Rd_data, out_csr_rd, out_csr_wr,
           out_csr_addr, out_csr_wr_data, out_ill, out_ill_addr, pend_cnt
  );
endinterface

// File: rtl/csr_fu_fwd.sv
// Registered CSR functional unit: decodes Zicsr ops, checks legality, and forwards
// not-yet-committed CSR writes so back-to-back read-modify-writes need no stall.
module csr_fu_fwd #(
  parameter int XLEN     = 32,
  parameter int GPR_ASZ  = 5,
  parameter int DEPTH    = 4,
  parameter int SEIP_BIT = 9
) (
  input  logic         clk_in,
  input  logic         reset_in,
  csr_fu_fwd_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    OP_BAD = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } op_e;

  // Pending-write buffer, circular between rd_ptr (oldest) and wr_ptr
  logic [11:0]     pend_addr_mem [DEPTH];
  logic [XLEN-1:0] pend_data_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   cnt_reg;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_rd_data_reg;
  logic            out_csr_rd_reg;
  logic            out_csr_wr_reg;
  logic [11:0]     out_csr_addr_reg;
  logic [XLEN-1:0] out_wr_data_reg;
  logic            out_ill_reg;
  logic [11:0]     out_ill_addr_reg;

  logic            req_ready;
  logic            accept;
  logic            push;
  logic            pop;

  logic [PW-1:0]   age_w [DEPTH];
  logic [DEPTH-1:0] hit_w;

  // Age of each slot relative to the oldest entry; only slots younger than cnt hold live data.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign age_w[gi] = PW'(gi) - rd_ptr_reg;
      assign hit_w[gi] = (CW'(age_w[gi]) < cnt_reg) &&
                         (pend_addr_mem[gi] == bus.csr_addr);
    end
  endgenerate

  logic            fwd_hit;
  logic [PW-1:0]   fwd_age;
  logic [XLEN-1:0] fwd_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_age  = '0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit_w[i] && (!fwd_hit || age_w[i] >= fwd_age)) begin
        fwd_hit  = 1'b1;
        fwd_age  = age_w[i];
        fwd_data = pend_data_mem[i];
      end
    end
  end

  op_e             op;
  logic            use_imm;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] src;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] seip_mask;
  logic            wr_c;
  logic            rd_c;
  logic            bad_op;
  logic            ill_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] rd_data_c;

  assign op        = op_e'(bus.funct3[1:0]);
  assign use_imm   = bus.funct3[2];
  assign imm       = XLEN'(bus.Rs1_addr);
  assign src       = use_imm ? imm : bus.Rs1_data;
  assign base      = fwd_hit ? fwd_data : bus.csr_rd_data;
  assign seip_mask = {{(XLEN-1){1'b0}}, bus.sw_irq} << SEIP_BIT;

  always_comb begin
    wr_c      = 1'b0;
    rd_c      = 1'b0;
    bad_op    = 1'b0;
    wdata_c   = '0;
    rd_data_c = '0;
    case (op)
      OP_RW: begin
        wr_c      = 1'b1;
        wdata_c   = src;
        rd_c      = (bus.Rd_addr != '0);
        rd_data_c = rd_c ? base : '0;
      end
      OP_RS: begin
        wr_c      = (bus.Rs1_addr != '0);
        wdata_c   = base | src;
        rd_c      = 1'b1;
        rd_data_c = base;
      end
      OP_RC: begin
        wr_c      = (bus.Rs1_addr != '0);
        wdata_c   = base & ~src;
        rd_c      = 1'b1;
        rd_data_c = base;
      end
      default: bad_op = 1'b1;
    endcase
    // SEIP is visible to register-form reads only and never leaks into the write data.
    if (!bad_op && !use_imm && bus.csr_addr[8:0] == 9'h144)
      rd_data_c = rd_data_c | seip_mask;
    ill_c = bad_op || (bus.mode < bus.csr_addr[9:8]) || !bus.csr_avail ||
            (wr_c && bus.csr_addr[11:10] == 2'b11);
  end

  assign req_ready = (!out_valid_reg || bus.out_ready) &&
                     ((cnt_reg < CW'(DEPTH)) || bus.retire) && !bus.flush;
  assign accept    = bus.req_valid && req_ready;
  assign push      = accept && !ill_c && wr_c;
  assign pop       = bus.retire && (cnt_reg != '0) && !bus.flush;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      out_valid_reg    <= 1'b0;
      out_rd_data_reg  <= '0;
      out_csr_rd_reg   <= 1'b0;
      out_csr_wr_reg   <= 1'b0;
      out_csr_addr_reg <= '0;
      out_wr_data_reg  <= '0;
      out_ill_reg      <= 1'b0;
      out_ill_addr_reg <= '0;
    end else if (accept) begin
      out_valid_reg    <= 1'b1;
      out_ill_reg      <= ill_c;
      out_ill_addr_reg <= ill_c ? bus.csr_addr : 12'h000;
      out_rd_data_reg  <= ill_c ? '0 : rd_data_c;
      out_csr_rd_reg   <= !ill_c && rd_c;
      out_csr_wr_reg   <= !ill_c && wr_c;
      out_csr_addr_reg <= ill_c ? 12'h000 : bus.csr_addr;
      out_wr_data_reg  <= ill_c ? '0 : wdata_c;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_reg    <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (bus.flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // When full, a push lands in the slot being retired on the same edge.
  always_ff @(posedge clk_in) begin
    if (push) begin
      pend_addr_mem[wr_ptr_reg] <= bus.csr_addr;
      pend_data_mem[wr_ptr_reg] <= wdata_c;
    end
  end

  assign bus.req_ready       = req_ready;
  assign bus.out_valid       = out_valid_reg;
  assign bus.out_Rd_data     = out_rd_data_reg;
  assign bus.out_csr_rd      = out_csr_rd_reg;
  assign bus.out_csr_wr      = out_csr_wr_reg;
  assign bus.out_csr_addr    = out_csr_addr_reg;
  assign bus.out_csr_wr_data = out_wr_data_reg;
  assign bus.out_ill         = out_ill_reg;
  assign bus.out_ill_addr    = out_ill_addr_reg;
  assign bus.pend_cnt        = cnt_reg;
endmodule

// File: tb/tb_csr_fu_fwd.sv
// Bench for csr_fu_fwd: queue-based reference model checked every cycle, plus
// directed transactions with hand-computed literal expectations.
module tb_csr_fu_fwd;
  localparam int XLEN  = 32;
  localparam int GASZ  = 5;
  localparam int DEPTH = 4;
  localparam int SEIP  = 9;

  logic clk_in;
  logic reset_in;
  int   checks   = 0;
  int   failures = 0;

  csr_fu_fwd_if #(.XLEN(XLEN), .GPR_ASZ(GASZ), .DEPTH(DEPTH)) bus ();

  csr_fu_fwd #(.XLEN(XLEN), .GPR_ASZ(GASZ), .DEPTH(DEPTH), .SEIP_BIT(SEIP)) dut (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding writes kept as a plain queue, oldest first.
  typedef struct packed { logic [11:0] a; logic [31:0] d; } pend_t;
  pend_t       pend_q[$];
  logic        m_valid, m_csr_rd, m_csr_wr, m_ill;
  logic [31:0] m_rd_data, m_wdata;
  logic [11:0] m_addr, m_ill_addr;
  logic        m_rdy, m_push, m_found, m_w, m_r, m_bad, m_illc;
  logic [31:0] m_base, m_src, m_wd, m_rdd;
  logic [2:0]  m_f;
  logic [11:0] m_a;

  always @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      m_valid = 0; m_csr_rd = 0; m_csr_wr = 0; m_ill = 0;
      m_rd_data = 0; m_wdata = 0; m_addr = 0; m_ill_addr = 0;
      pend_q.delete();
    end else begin
      m_rdy  = (!m_valid || bus.out_ready) && (pend_q.size() < DEPTH || bus.retire) && !bus.flush;
      m_push = 0;
      if (bus.req_valid && m_rdy) begin
        m_f = bus.funct3;
        m_a = bus.csr_addr;
        m_src = m_f[2] ? {27'd0, bus.Rs1_addr} : bus.Rs1_data;
        m_found = 0;
        m_base = bus.csr_rd_data;
        for (int i = pend_q.size() - 1; i >= 0; i--)
          if (!m_found && pend_q[i].a == m_a) begin m_base = pend_q[i].d; m_found = 1; end
        m_w = 0; m_r = 0; m_wd = 0; m_rdd = 0; m_bad = 0;
        if (m_f == 3'd1 || m_f == 3'd5) begin
          m_w = 1; m_wd = m_src; m_r = (bus.Rd_addr != 0); m_rdd = m_r ? m_base : 0;
        end else if (m_f == 3'd2 || m_f == 3'd6) begin
          m_w = (bus.Rs1_addr != 0); m_wd = m_base | m_src; m_r = 1; m_rdd = m_base;
        end else if (m_f == 3'd3 || m_f == 3'd7) begin
          m_w = (bus.Rs1_addr != 0); m_wd = m_base & ~m_src; m_r = 1; m_rdd = m_base;
        end else m_bad = 1;
        if (m_f >= 3'd1 && m_f <= 3'd3 && m_a[8:0] == 9'h144 && bus.sw_irq)
          m_rdd = m_rdd | (32'd1 << SEIP);
        m_illc = m_bad || (bus.mode < m_a[9:8]) || !bus.csr_avail || (m_w && m_a[11:10] == 2'b11);
        m_valid    = 1;
        m_ill      = m_illc;
        m_ill_addr = m_illc ? m_a : 12'h000;
        m_rd_data  = m_illc ? 0 : m_rdd;
        m_csr_rd   = !m_illc && m_r;
        m_csr_wr   = !m_illc && m_w;
        m_addr     = m_illc ? 12'h000 : m_a;
        m_wdata    = m_illc ? 0 : m_wd;
        m_push     = !m_illc && m_w;
      end else if (bus.flush || bus.out_ready) begin
        m_valid = 0;
      end
      if (bus.flush) pend_q.delete();
      else begin
        if (bus.retire && pend_q.size() > 0) void'(pend_q.pop_front());
        if (m_push) pend_q.push_back('{a: m_a, d: m_wd});
      end
    end
  end

  always @(negedge clk_in) begin
    if (!reset_in) begin
      chk("m_req_ready", {31'd0, bus.req_ready},
          {31'd0, (!m_valid || bus.out_ready) && (pend_q.size() < DEPTH || bus.retire) && !bus.flush});
      chk("m_out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
      chk("m_pend_cnt", {29'd0, bus.pend_cnt}, pend_q.size());
      if (m_valid) begin
        chk("m_rd_data", bus.out_Rd_data, m_rd_data);
        chk("m_csr_rd", {31'd0, bus.out_csr_rd}, {31'd0, m_csr_rd});
        chk("m_csr_wr", {31'd0, bus.out_csr_wr}, {31'd0, m_csr_wr});
        chk("m_csr_addr", {20'd0, bus.out_csr_addr}, {20'd0, m_addr});
        chk("m_wr_data", bus.out_csr_wr_data, m_wdata);
        chk("m_ill", {31'd0, bus.out_ill}, {31'd0, m_ill});
        chk("m_ill_addr", {20'd0, bus.out_ill_addr}, {20'd0, m_ill_addr});
      end
    end
  end

  task automatic issue(input logic [11:0] a, input logic [2:0] f, input logic [4:0] rd,
                       input logic [4:0] rs1a, input logic [31:0] rs1d, input logic [31:0] crd);
    logic ok;
    bus.csr_addr = a; bus.funct3 = f; bus.Rd_addr = rd; bus.Rs1_addr = rs1a;
    bus.Rs1_data = rs1d; bus.csr_rd_data = crd; bus.req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk_in);
      ok = bus.req_ready;
      @(posedge clk_in);
      #1;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL issue_timeout actual=no_accept expected=accept addr=%03h", a);
    end
    $display("txn addr=%03h f3=%0d rd=x%0d rs1=%0h/%08h -> valid=%0b rd_data=%08h wr=%0b wdata=%08h ill=%0b pend=%0d",
             a, f, rd, rs1a, rs1d, bus.out_valid, bus.out_Rd_data, bus.out_csr_wr,
             bus.out_csr_wr_data, bus.out_ill, bus.pend_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1;
    bus.req_valid = 0; bus.csr_addr = 0; bus.funct3 = 0; bus.Rd_addr = 0; bus.Rs1_addr = 0;
    bus.Rs1_data = 0; bus.mode = 2'd3; bus.csr_avail = 1; bus.csr_rd_data = 0; bus.sw_irq = 0;
    bus.flush = 0; bus.retire = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk_in);
    #1 reset_in = 1'b0;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_pend_cnt", {29'd0, bus.pend_cnt}, 32'd0);
    chk("reset_rd_data", bus.out_Rd_data, 32'd0);
    chk("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Forwarding: CSRRS then CSRRC on 0x300 with nothing retired
    issue(12'h300, 3'd2, 5'd5, 5'd1, 32'h3, 32'h8);
    chk("fwd1_rd", bus.out_Rd_data, 32'h8);
    chk("fwd1_wdata", bus.out_csr_wr_data, 32'hB);
    issue(12'h300, 3'd3, 5'd6, 5'd2, 32'h1, 32'h8);
    chk("fwd2_rd", bus.out_Rd_data, 32'hB);
    chk("fwd2_wdata", bus.out_csr_wr_data, 32'hA);
    chk("fwd2_pend", {29'd0, bus.pend_cnt}, 32'd2);

    // Asynchronous reset mid-transfer
    #1 reset_in = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_rst_pend", {29'd0, bus.pend_cnt}, 32'd0);
    #1 reset_in = 1'b0;

    // Read-only CSR: read legal, write illegal
    issue(12'hC00, 3'd2, 5'd3, 5'd0, 32'h0, 32'h1234);
    chk("ro_read_ill", {31'd0, bus.out_ill}, 32'd0);
    chk("ro_read_wr", {31'd0, bus.out_csr_wr}, 32'd0);
    chk("ro_read_rd", bus.out_Rd_data, 32'h1234);
    issue(12'hC00, 3'd1, 5'd3, 5'd4, 32'h55, 32'h1234);
    chk("ro_write_ill", {31'd0, bus.out_ill}, 32'd1);
    chk("ro_write_addr", {20'd0, bus.out_ill_addr}, 32'hC00);
    chk("ro_write_rd", bus.out_Rd_data, 32'd0);

    // Privilege and SEIP
    bus.mode = 2'd0;
    issue(12'h344, 3'd2, 5'd1, 5'd1, 32'h1, 32'h0);
    chk("priv_ill", {31'd0, bus.out_ill}, 32'd1);
    bus.mode = 2'd3; bus.sw_irq = 1'b1;
    issue(12'h344, 3'd2, 5'd1, 5'd0, 32'h0, 32'h0);
    chk("seip_rd", bus.out_Rd_data, 32'h200);
    chk("seip_wdata", bus.out_csr_wr_data, 32'h0);
    issue(12'h344, 3'd6, 5'd1, 5'd0, 32'h0, 32'h0);
    chk("seip_imm_rd", bus.out_Rd_data, 32'h0);
    bus.sw_irq = 1'b0;
    issue(12'h300, 3'd4, 5'd1, 5'd1, 32'h1, 32'h0);
    chk("bad_f3_ill", {31'd0, bus.out_ill}, 32'd1);
    chk("bad_f3_pend", {29'd0, bus.pend_cnt}, 32'd0);

    // Fill the buffer, then retire alongside the 5th request
    for (int k = 1; k <= DEPTH; k++) issue(12'h340, 3'd1, 5'd1, 5'd7, k, 32'h99);
    bus.csr_addr = 12'h340; bus.funct3 = 3'd1; bus.Rd_addr = 5'd1; bus.Rs1_addr = 5'd7;
    bus.Rs1_data = 32'd5; bus.req_valid = 1'b1;
    @(negedge clk_in);
    chk("full_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("full_pend", {29'd0, bus.pend_cnt}, 32'd4);
    #1 bus.retire = 1'b1;
    #1 chk("full_retire_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk_in);
    #1 bus.req_valid = 1'b0; bus.retire = 1'b0;
    chk("full_push_pop_pend", {29'd0, bus.pend_cnt}, 32'd4);
    chk("full_youngest_rd", bus.out_Rd_data, 32'd4);
    chk("full_wdata", bus.out_csr_wr_data, 32'd5);
    $display("txn addr=340 f3=1 with retire -> rd_data=%08h pend=%0d", bus.out_Rd_data, bus.pend_cnt);

    // Drain two, then hold output under backpressure
    bus.retire = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 bus.retire = 1'b0;
    bus.out_ready = 1'b0;
    issue(12'h340, 3'd2, 5'd2, 5'd0, 32'h0, 32'h99);
    for (int c = 0; c < 3; c++) begin
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_rd", bus.out_Rd_data, 32'd5);
      chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk_in);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk_in);
    #1;

    // Flush with retire discards everything
    issue(12'h340, 3'd1, 5'd1, 5'd7, 32'd6, 32'h99);
    chk("pre_flush_pend", {29'd0, bus.pend_cnt}, 32'd3);
    chk("pre_flush_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.flush = 1'b1; bus.retire = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk_in);
    #1 bus.flush = 1'b0; bus.retire = 1'b0; bus.out_ready = 1'b1;
    chk("flush_pend", {29'd0, bus.pend_cnt}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    issue(12'h340, 3'd2, 5'd3, 5'd0, 32'h0, 32'h77);
    chk("post_flush_rd", bus.out_Rd_data, 32'h77);

    repeat (3) @(posedge clk_in);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
